// File: rtl/scan_pkg.sv
// Shared types and constants for the raster-scan axis counters.
// Pure declarations: no latency, no flow control.
// The engine and top level instantiate the X/Y counters from these constants.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } axis_state_t;

    localparam int SCAN_WIDTH  = 12;
    localparam int NEAR_LEAD_X = 1;
    localparam int NEAR_LEAD_Y = 0;

endpackage

// File: rtl/scan_axis_counter.sv
// Per-axis position counter answering the raster engine's start/enable handshake.
// Latency: every output is registered and updates one cycle after the sampled inputs.
// Backpressure: enable low stalls the count; enable outside a run only flags overrun.
import scan_pkg::*;

module scan_axis_counter #(
    parameter int WIDTH     = SCAN_WIDTH,
    parameter int NEAR_LEAD = NEAR_LEAD_X
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] length_i,
    output logic [WIDTH-1:0] count_o,
    output logic             near_end_o,
    output logic             last_o,
    output logic             active_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam logic [WIDTH-1:0]        ONE    = WIDTH'(1);
    localparam logic signed [WIDTH+1:0] LEAD_S = (WIDTH+2)'(NEAR_LEAD + 1);

    axis_state_t      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             near_q, near_d;
    logic             last_q, last_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] len_load;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] len_m1;

    // Threshold len-1-NEAR_LEAD is evaluated two bits wider and signed so
    // runs shorter than the lead go negative instead of wrapping.
    function automatic logic near_at(input logic [WIDTH-1:0] cnt,
                                     input logic [WIDTH-1:0] len);
        logic signed [WIDTH+1:0] thr;
        thr = $signed({2'b00, len}) - LEAD_S;
        return $signed({2'b00, cnt}) >= thr;
    endfunction

    assign len_load  = (length_i == '0) ? ONE : length_i;
    assign count_inc = count_q + ONE;
    assign len_m1    = len_q - ONE;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        near_d    = near_q;
        last_d    = last_q;
        active_d  = active_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        if (start_i) begin
            // A start on the last enabled position is the seamless wrap: no done.
            state_d   = RUN;
            count_d   = '0;
            len_d     = len_load;
            near_d    = near_at('0, len_load);
            last_d    = (len_load == ONE);
            active_d  = 1'b1;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable_i) begin
                        if (count_q == len_m1) begin
                            state_d  = DONE;
                            near_d   = 1'b0;
                            last_d   = 1'b0;
                            active_d = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            count_d = count_inc;
                            near_d  = near_at(count_inc, len_q);
                            last_d  = (count_inc == len_m1);
                        end
                    end
                end
                IDLE, DONE: begin
                    if (enable_i) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            len_q     <= ONE;
            near_q    <= 1'b0;
            last_q    <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            near_q    <= near_d;
            last_q    <= last_d;
            active_q  <= active_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign count_o    = count_q;
    assign near_end_o = near_q;
    assign last_o     = last_q;
    assign active_o   = active_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_scan_axis_counter.sv
// Drives an X-style (lead 1) and a Y-style (lead 0) counter with the same strobes
// and compares both against a plain integer model of the run rules.
module tb_scan_axis_counter;
    import scan_pkg::*;

    localparam int W = SCAN_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         enable_i;
    logic [W-1:0] length_i;

    logic [W-1:0] x_count, y_count;
    logic         x_near, y_near, x_last, y_last;
    logic         x_active, y_active, x_done, y_done, x_ovr, y_ovr;

    int errors = 0;
    int checks = 0;

    int m_len = 1;
    int m_cnt = 0;
    bit m_run = 0;
    bit m_done = 0;
    bit m_ovr = 0;

    always #5 clk = ~clk;

    scan_axis_counter #(.WIDTH(W), .NEAR_LEAD(NEAR_LEAD_X)) dut_x (
        .clk(clk), .rst(rst), .start_i(start_i), .enable_i(enable_i),
        .length_i(length_i), .count_o(x_count), .near_end_o(x_near),
        .last_o(x_last), .active_o(x_active), .done_o(x_done), .overrun_o(x_ovr)
    );

    scan_axis_counter #(.WIDTH(W), .NEAR_LEAD(NEAR_LEAD_Y)) dut_y (
        .clk(clk), .rst(rst), .start_i(start_i), .enable_i(enable_i),
        .length_i(length_i), .count_o(y_count), .near_end_o(y_near),
        .last_o(y_last), .active_o(y_active), .done_o(y_done), .overrun_o(y_ovr)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: one cycle of the run rules in plain integer arithmetic.
    task automatic model(input bit r, input bit s, input bit e, input int len);
        if (r) begin
            m_len = 1; m_cnt = 0; m_run = 0; m_done = 0; m_ovr = 0;
        end else if (s) begin
            m_len = (len == 0) ? 1 : len;
            m_cnt = 0; m_run = 1; m_done = 0; m_ovr = 0;
        end else if (m_run) begin
            m_done = 0;
            if (e) begin
                if (m_cnt == m_len - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            m_done = 0;
            if (e) m_ovr = 1;
        end
    endtask

    function automatic int exp_near(input int lead);
        return (m_run && (m_cnt >= m_len - 1 - lead)) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        int exp_last;
        exp_last = (m_run && m_cnt == m_len - 1) ? 1 : 0;
        chk({tag, ".x.count"},  int'(x_count),  m_cnt);
        chk({tag, ".x.near"},   int'(x_near),   exp_near(1));
        chk({tag, ".x.last"},   int'(x_last),   exp_last);
        chk({tag, ".x.active"}, int'(x_active), int'(m_run));
        chk({tag, ".x.done"},   int'(x_done),   int'(m_done));
        chk({tag, ".x.ovr"},    int'(x_ovr),    int'(m_ovr));
        chk({tag, ".y.count"},  int'(y_count),  m_cnt);
        chk({tag, ".y.near"},   int'(y_near),   exp_near(0));
        chk({tag, ".y.last"},   int'(y_last),   exp_last);
        chk({tag, ".y.active"}, int'(y_active), int'(m_run));
        chk({tag, ".y.done"},   int'(y_done),   int'(m_done));
        chk({tag, ".y.ovr"},    int'(y_ovr),    int'(m_ovr));
    endtask

    task automatic step(input string tag, input bit r, input bit s, input bit e,
                        input int len);
        rst      = r;
        start_i  = s;
        enable_i = e;
        length_i = W'(len);
        @(posedge clk);
        #1;
        model(r, s, e, len);
        check_all(tag);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start_i = 1'b0; enable_i = 1'b0; length_i = '0;

        step("reset0", 1, 0, 0, 0);
        step("reset1", 1, 0, 0, 0);
        step("idle",   0, 0, 0, 0);

        // length 4, enable held: 0,1,2,3 then done, hold at 3
        step("l4.start", 0, 1, 0, 4);
        for (int i = 0; i < 5; i++) step("l4.run", 0, 0, 1, 0);
        chk("l4.hold_count", int'(x_count), 3);

        // seamless wrap: start in the cycle after near_end is seen at count 2
        step("wrap.start", 0, 1, 0, 4);
        step("wrap.c1", 0, 0, 1, 0);
        step("wrap.c2", 0, 0, 1, 0);
        step("wrap.c3", 0, 0, 1, 0);
        step("wrap.restart", 0, 1, 1, 4);
        chk("wrap.count0", int'(x_count), 0);
        chk("wrap.active", int'(x_active), 1);
        step("wrap.c1b", 0, 0, 1, 0);
        chk("wrap.count1", int'(x_count), 1);

        // length 3 with stalls: enable 1,0,0,1,1
        step("stall.start", 0, 1, 0, 3);
        step("stall.e1", 0, 0, 1, 0);
        step("stall.e0a", 0, 0, 0, 0);
        step("stall.e0b", 0, 0, 0, 0);
        chk("stall.near_hold", int'(x_near), 1);
        step("stall.e1b", 0, 0, 1, 0);
        chk("stall.count2", int'(x_count), 2);
        step("stall.e1c", 0, 0, 1, 0);

        // length 0 then length 1 both behave as single-position runs
        step("len0.start", 0, 1, 0, 0);
        chk("len0.last", int'(x_last), 1);
        step("len0.en", 0, 0, 1, 0);
        chk("len0.done", int'(x_done), 1);
        step("len1.start", 0, 1, 0, 1);
        step("len1.en", 0, 0, 1, 0);

        // overrun is sticky until the next start
        step("ovr.en1", 0, 0, 1, 0);
        step("ovr.en2", 0, 0, 1, 0);
        step("ovr.idle", 0, 0, 0, 0);
        chk("ovr.sticky", int'(x_ovr), 1);
        step("ovr.start5", 0, 1, 0, 5);
        chk("ovr.cleared", int'(x_ovr), 0);

        // reset mid-run at count 2 of a length-8 run
        step("rst.start8", 0, 1, 0, 8);
        step("rst.c1", 0, 0, 1, 0);
        step("rst.c2", 0, 0, 1, 0);
        step("rst.abort", 1, 0, 1, 0);
        chk("rst.no_done", int'(x_done), 0);
        step("rst.after", 0, 0, 0, 0);

        // random strobes, short lengths so runs end often
        done_seen = 0;
        for (int i = 0; i < 600; i++) begin
            bit r, s, e;
            int len;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 12);
            e   = ($urandom_range(0, 99) < 70);
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                              : int'($urandom_range(0, 6));
            step("rand", r, s, e, len);
            if (m_done) done_seen++;
        end
        checks++;
        assert (done_seen > 0) else begin
            errors++;
            $error("FAIL rand.done_coverage observed=%0d expected=>0", done_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_axis_counter.md
# scan_axis_counter

Position counter that answers the raster engine's per-axis control handshake. One instance serves the X axis (pixel within line) and one serves the Y axis (line within frame). Each instance takes the engine's `start`/`enable` strobes, counts positions against a run length latched at start, and returns the `near_end` look-ahead. The engine uses `near_end` to issue the next `start` with no idle cycle. It sits between the engine control FSM and the datapath address logic, which consumes `count`.

## Interface
- `WIDTH`, default 12: width of `length` and `count`; maximum run length 2^WIDTH-1.
- `NEAR_LEAD`, default 1: number of cycles `near_end` leads the last position; 0 makes `near_end` equal to `last`. Legal range is 0..3.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  load `length`, restart the count at 0, clear `overrun`.
- `enable`  in  1  advance by one position per cycle while running.
- `length`  in  WIDTH  run length in positions; sampled only on a `start` cycle.
- `count`  out  WIDTH  current position, 0..len_q-1.
- `near_end`  out  1  level; high while `count` >= len_q-1-NEAR_LEAD and `active`.
- `last`  out  1  level; high while `count` == len_q-1 and `active`.
- `active`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a run ends without a restart.
- `overrun`  out  1  sticky; set when `enable` arrives in DONE.

## Operation
- Reset values: all outputs 0, `len_q` = 1, state IDLE.
- FSM states are IDLE, RUN and DONE. Transitions:
  - `start` from any state → RUN, with `count` = 0 and `len_q` = max(`length`, 1). A `length` of 0 is treated as 1.
  - `start` is accepted whether or not `enable` is high. The load cycle never counts as an increment.
  - RUN, `enable` = 1, `count` < len_q-1 → `count` + 1.
  - RUN, `enable` = 1, `count` == len_q-1, no `start` → DONE. `count` holds at len_q-1, `active` drops and `done` pulses for 1 cycle.
  - RUN, `enable` = 0 → hold `count`. `near_end` and `last` hold because they depend on `count` alone.
  - DONE or IDLE with `enable` = 1 and no `start` → set `overrun`. The state does not change.
- `start` mid-run (`count` < len_q-1) is a legal early restart: reload with the new `length`, no `done` pulse.
- Simultaneous `start` with `enable` on the last position is a seamless wrap: next `count` = 0, state stays RUN, no `done` pulse.
- `overrun` clears only on `start` or `rst`.
- `near_end` when len_q <= NEAR_LEAD: high from the first RUN cycle (`count` = 0).
- Arithmetic:
  - `count` is unsigned WIDTH bits and never wraps past len_q-1.
  - The comparison len_q-1-NEAR_LEAD is done in WIDTH+2 signed bits, so short lengths do not underflow.
- `rst` mid-run aborts immediately: outputs return to their reset values the next cycle and there is no `done` pulse.

## Timing
- All outputs are registered and update the cycle after the sampled inputs.
- Start latency: `start` sampled at edge N → `count` = 0, `active` = 1 after edge N.
- `near_end` is registered together with `count`, so `near_end` and `count` change on the same edge.
- Seamless restart with NEAR_LEAD = 1:
  - The engine samples `near_end` at edge N and drives `start` high during cycle N+1.
  - The counter is at len_q-1 during cycle N+1 and shows `count` = 0 after edge N+1.
  - There is no gap and no repeated position.
- `done` is high for exactly the cycle after the final increment edge.

## Structure
- Shared package `scan_pkg` holds:
  - `axis_state_t` (IDLE, RUN, DONE);
  - the default `SCAN_WIDTH` = 12;
  - `NEAR_LEAD_X` = 1 and `NEAR_LEAD_Y` = 0.
- The engine and the top level use these constants when instantiating the counters.
- One module with a single FSM and a count register. No sub-module is needed; the X and Y axes are two instances of this block.

## Test plan
- `length` = 4, NEAR_LEAD = 1, `start` for 1 cycle then `enable` held high:
  - `count` runs 0,1,2,3;
  - `near_end` is high on counts 2,3;
  - `last` is high on count 3;
  - `done` pulses once, then `active` = 0 and `count` holds at 3.
- Same setup, but `start` is driven the cycle after `near_end` first rises: `count` runs 0,1,2,3,0,1,… with no `done` pulse and `active` held at 1.
- `length` = 3 with `enable` toggled 1,0,0,1,1:
  - `count` runs 0,1,1,1,2;
  - `near_end` stays high from count 1 through the stalls.
- `length` = 0, then `length` = 1 with NEAR_LEAD = 1:
  - each run is treated as length 1;
  - `near_end` and `last` are high in the first cycle;
  - `done` pulses on the next `enable`.
- `enable` held high for 2 cycles after DONE:
  - `overrun` goes to 1 and stays there;
  - a subsequent `start` with `length` = 5 clears it and `count` restarts at 0.
- Assert `rst` at `count` = 2 of a `length` = 8 run: the next cycle shows all outputs at 0, state IDLE and no `done` pulse.
